// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_arbiter (with helper regbank_wb_fifo)
// Purpose  : Shares the single register-bank write port between the ALU and
//            memory-load writeback sources. Each source has its own small
//            FIFO. A registered output stage drives the bank. A pending
//            scoreboard marks every register with an in-flight write.
// Ports    : clk, rst_n          - clock, async active-low reset
//            alu_valid/ready/addr/data - ALU writeback handshake
//            mem_valid/ready/addr/data - load writeback handshake
//            regWrite/writeReg/writeData - bank write port (registered)
//            pending            - per-register in-flight write map
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Per-source writeback FIFO. Writes to r0 are swallowed at the input. The
// occupancy bits feed the pending map.
// ----------------------------------------------------------------------------
module regbank_wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   pop,
  output logic                   nonempty,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [2**ADDR_W-1:0]   pend
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]   r_occ;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               r_ready;
  logic               w_push;
  logic               w_enq;
  logic               w_pop;

  // The handshake completes on valid && ready even for r0; only non-zero
  // destinations take a slot.
  assign w_push    = in_valid && r_ready;
  assign w_enq     = w_push && (in_addr != '0);
  assign w_pop     = pop && nonempty;
  assign nonempty  = (r_count != '0);
  assign in_ready  = r_ready;
  assign head_addr = r_addr[r_rptr];
  assign head_data = r_data[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq) w_count_nxt = w_count_nxt + c_CNT_W'(1);
    if (w_pop) w_count_nxt = w_count_nxt - c_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // Ready reflects the occupancy after this edge, so a full FIFO that is
      // draining still shows ready=0 for that cycle.
      r_ready <= (w_count_nxt != c_FULL);
      if (w_enq) begin
        r_wptr        <= r_wptr + c_PTR_W'(1);
        r_occ[r_wptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr        <= r_rptr + c_PTR_W'(1);
        r_occ[r_rptr] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; r_occ qualifies every use of it.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wptr] <= in_addr;
      r_data[r_wptr] <= in_data;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_occ[i]) pend[r_addr[i]] = 1'b1;
    end
  end
endmodule

// ----------------------------------------------------------------------------
// Top: arbitration, starvation counter, output stage and pending map.
// ----------------------------------------------------------------------------
module regbank_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    writeReg,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**ADDR_W-1:0] pending
);
  localparam int c_NREG   = 2**ADDR_W;
  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

  logic                w_alu_ne;
  logic                w_mem_ne;
  logic [ADDR_W-1:0]   w_alu_head_addr;
  logic [ADDR_W-1:0]   w_mem_head_addr;
  logic [DATA_W-1:0]   w_alu_head_data;
  logic [DATA_W-1:0]   w_mem_head_data;
  logic [c_NREG-1:0]   w_alu_pend;
  logic [c_NREG-1:0]   w_mem_pend;
  logic [c_NREG-1:0]   w_out_pend;
  logic [c_NREG-1:0]   w_pending;
  logic                w_grant_alu;
  logic                w_grant_mem;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_regwrite;
  logic [ADDR_W-1:0]   r_write_reg;
  logic [DATA_W-1:0]   r_write_data;

  regbank_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (alu_valid),
    .in_ready  (alu_ready),
    .in_addr   (alu_addr),
    .in_data   (alu_data),
    .pop       (w_grant_alu),
    .nonempty  (w_alu_ne),
    .head_addr (w_alu_head_addr),
    .head_data (w_alu_head_data),
    .pend      (w_alu_pend)
  );

  regbank_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mem_valid),
    .in_ready  (mem_ready),
    .in_addr   (mem_addr),
    .in_data   (mem_data),
    .pop       (w_grant_mem),
    .nonempty  (w_mem_ne),
    .head_addr (w_mem_head_addr),
    .head_data (w_mem_head_data),
    .pend      (w_mem_pend)
  );

  // Loads normally win; the ALU is forced through once it has lost
  // MAX_WAIT arbitrations in a row.
  assign w_grant_alu = w_alu_ne && (!w_mem_ne || (r_wait_cnt == c_MAX_WAIT));
  assign w_grant_mem = w_mem_ne && !w_grant_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!w_alu_ne || w_grant_alu) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
    end
  end

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= w_grant_alu || w_grant_mem;
      if (w_grant_alu) begin
        r_write_reg  <= w_alu_head_addr;
        r_write_data <= w_alu_head_data;
      end else if (w_grant_mem) begin
        r_write_reg  <= w_mem_head_addr;
        r_write_data <= w_mem_head_data;
      end
    end
  end

  assign regWrite  = r_regwrite;
  assign writeReg  = r_write_reg;
  assign writeData = r_write_data;

  always_comb begin
    w_out_pend = '0;
    if (r_regwrite) w_out_pend[r_write_reg] = 1'b1;
  end

  always_comb begin
    w_pending    = w_alu_pend | w_mem_pend | w_out_pend;
    w_pending[0] = 1'b0;
  end

  assign pending = w_pending;
endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_write_arbiter
// Purpose  : Directed self-checking bench for regbank_write_arbiter. Every
//            bank write is logged on the falling edge and compared against
//            hand-derived sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  logic [36:0] log_q [$];
  logic [36:0] exp_q [$];

  regbank_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && regWrite) log_q.push_back({writeReg, writeData});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] ent(input logic [4:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic compare_log(input string tag);
    logic [36:0] obs;
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      obs = (i < log_q.size()) ? log_q[i] : 'x;
      check($sformatf("%s[%0d]", tag, i), 64'(obs), 64'(exp_q[i]));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // ---------------- power-on reset ----------------
    #2 rst_n = 1'b0;
    #1;
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_writeReg", 64'(writeReg), 64'd0);
    check("rst_writeData", 64'(writeData), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);

    // ---------------- single write r5 ----------------
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    step();                                  // accepted here
    alu_valid = 1'b0;
    check("single_pend_queued", 64'(pending), 64'h20);
    check("single_regWrite_early", 64'(regWrite), 64'd0);
    step();
    check("single_regWrite", 64'(regWrite), 64'd1);
    check("single_writeReg", 64'(writeReg), 64'd5);
    check("single_writeData", 64'(writeData), 64'hDEADBEEF);
    check("single_pend_out", 64'(pending), 64'h20);
    step();
    check("single_regWrite_after", 64'(regWrite), 64'd0);
    check("single_pend_after", 64'(pending), 64'd0);
    check("single_hold_addr", 64'(writeReg), 64'd5);
    check("single_hold_data", 64'(writeData), 64'hDEADBEEF);
    exp_q.push_back(ent(5'd5, 32'hDEADBEEF));
    compare_log("single_log");

    // ---------------- contention ----------------
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
    step();
    alu_addr = 5'd2; alu_data = 32'h22;
    mem_addr = 5'd4; mem_data = 32'h44;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("cont_pending", 64'(pending), 64'h1E);
    check("cont_alu_full", 64'(alu_ready), 64'd0);
    repeat (5) step();
    exp_q.push_back(ent(5'd3, 32'h33));
    exp_q.push_back(ent(5'd4, 32'h44));
    exp_q.push_back(ent(5'd1, 32'h11));
    exp_q.push_back(ent(5'd2, 32'h22));
    compare_log("cont_log");

    // ---------------- starvation ----------------
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h80;
    step();
    alu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mem_data = 32'h80 + 32'(k);
      step();
    end
    mem_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(5'd8, 32'h80 + 32'(k)));
    exp_q.push_back(ent(5'd7, 32'h77));
    exp_q.push_back(ent(5'd8, 32'h84));
    exp_q.push_back(ent(5'd8, 32'h85));
    compare_log("starve_log");

    // wait counter must be back at 0: loads win the next tie again
    alu_valid = 1'b1; alu_addr = 5'd17; alu_data = 32'h171;
    mem_valid = 1'b1; mem_addr = 5'd18; mem_data = 32'h181;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (4) step();
    exp_q.push_back(ent(5'd18, 32'h181));
    exp_q.push_back(ent(5'd17, 32'h171));
    compare_log("wait_clear_log");

    // ---------------- full / backpressure ----------------
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h91;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'hA0;
    step();
    check("full_ready_1push", 64'(alu_ready), 64'd1);
    alu_addr = 5'd12; alu_data = 32'h92; mem_data = 32'hA1;
    step();
    check("full_ready_2push", 64'(alu_ready), 64'd0);
    alu_addr = 5'd13; alu_data = 32'h93;     // third request, must be refused
    for (int k = 2; k <= 4; k++) begin
      mem_data = 32'hA0 + 32'(k);
      step();
      check($sformatf("full_ready_hold%0d", k), 64'(alu_ready), 64'd0);
    end
    mem_data = 32'hA5;
    step();                                  // alu pops here, ready still 0 at the edge
    check("full_ready_after_pop", 64'(alu_ready), 64'd1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(5'd10, 32'hA0 + 32'(k)));
    exp_q.push_back(ent(5'd9, 32'h91));
    exp_q.push_back(ent(5'd10, 32'hA4));
    exp_q.push_back(ent(5'd10, 32'hA5));
    exp_q.push_back(ent(5'd12, 32'h92));
    compare_log("full_log");

    // ---------------- r0 drop ----------------
    check("r0_ready_before", 64'(mem_ready), 64'd1);
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
    step();
    mem_valid = 1'b0;
    check("r0_pending", 64'(pending), 64'd0);
    check("r0_ready_after", 64'(mem_ready), 64'd1);
    step();
    check("r0_regWrite", 64'(regWrite), 64'd0);
    repeat (3) step();
    compare_log("r0_log");

    // ---------------- reset mid-burst ----------------
    alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'hE;
    mem_valid = 1'b1; mem_addr = 5'd15; mem_data = 32'hF;
    step();
    alu_addr = 5'd13; alu_data = 32'hD;
    mem_valid = 1'b0;
    step();
    alu_valid = 1'b0;
    check("mid_pending", 64'(pending), 64'hE000);
    check("mid_regWrite", 64'(regWrite), 64'd1);
    log_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_regWrite", 64'(regWrite), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_writeReg", 64'(writeReg), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("mid_alu_ready", 64'(alu_ready), 64'd1);
    check("mid_mem_ready", 64'(mem_ready), 64'd1);
    repeat (4) step();
    check("mid_pending_after", 64'(pending), 64'd0);
    compare_log("mid_log");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
